// File: rtl/seq_divider.sv
// Sequential signed restoring divider: OUTPUT_WIDTH-bit dividend / INPUT_WIDTH-bit divisor,
// quotient truncated toward zero, remainder carrying the dividend's sign.
module seq_divider #(
   parameter int INPUT_WIDTH  = 6,
   parameter int OUTPUT_WIDTH = 12,
   parameter int COUNTER_SIZE = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start_in,
   input  logic [OUTPUT_WIDTH-1:0] dividend_in,
   input  logic [INPUT_WIDTH-1:0]  divisor_in,
   output logic [INPUT_WIDTH-1:0]  quotient_out,
   output logic [INPUT_WIDTH-1:0]  remainder_out,
   output logic                    busy_out,
   output logic                    done_out,
   output logic                    div_zero_out,
   output logic                    overflow_out,
   output logic [COUNTER_SIZE-1:0] counter_out,
   output logic [1:0]              state_out
);

   // Handshake: start_in is sampled only in IDLE; busy_out rises on that edge and falls on
   // the edge that raises done_out, which is high for exactly one cycle. No request queueing.
   typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, RUN = 2'd2, FINISH = 2'd3} state_t;

   localparam logic [COUNTER_SIZE-1:0] LAST_STEP = COUNTER_SIZE'(OUTPUT_WIDTH - 1);
   localparam logic [OUTPUT_WIDTH-1:0] Q_LIM_POS = OUTPUT_WIDTH'(2 ** (INPUT_WIDTH - 1) - 1);
   localparam logic [OUTPUT_WIDTH-1:0] Q_LIM_NEG = OUTPUT_WIDTH'(2 ** (INPUT_WIDTH - 1));

   state_t state, state_nxt;

   logic [OUTPUT_WIDTH-1:0] dvd_r;    // operand, then magnitude, then shifted-in quotient
   logic [INPUT_WIDTH-1:0]  dvs_r;    // operand, then magnitude
   logic                    dvd_neg;
   logic                    dvs_neg;
   logic                    dz_r;
   logic [INPUT_WIDTH:0]    prem_r;
   logic [COUNTER_SIZE-1:0] counter_r;

   logic [INPUT_WIDTH:0]    prem_shift;
   logic [INPUT_WIDTH+1:0]  trial;
   logic                    trial_ok;
   logic                    sign_diff;
   logic                    q_ovf;
   logic [INPUT_WIDTH-1:0]  q_val;
   logic [INPUT_WIDTH-1:0]  r_val;

   assign state_out   = state;
   assign counter_out = counter_r;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_in) state_nxt = PREP;
         PREP:    state_nxt = (dvs_r == '0) ? FINISH : RUN;
         RUN:     if (counter_r == LAST_STEP) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      prem_shift = {prem_r[INPUT_WIDTH-1:0], dvd_r[OUTPUT_WIDTH-1]};
      trial      = {1'b0, prem_shift} - {2'b00, dvs_r};
      trial_ok   = ~trial[INPUT_WIDTH+1];
      sign_diff  = dvd_neg ^ dvs_neg;
      // A negative quotient can reach one step further than a positive one.
      q_ovf      = sign_diff ? (dvd_r > Q_LIM_NEG) : (dvd_r > Q_LIM_POS);
      q_val      = sign_diff ? -dvd_r[INPUT_WIDTH-1:0] : dvd_r[INPUT_WIDTH-1:0];
      r_val      = dvd_neg ? -prem_r[INPUT_WIDTH-1:0] : prem_r[INPUT_WIDTH-1:0];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         dvd_r         <= '0;
         dvs_r         <= '0;
         dvd_neg       <= 1'b0;
         dvs_neg       <= 1'b0;
         dz_r          <= 1'b0;
         prem_r        <= '0;
         counter_r     <= '0;
         quotient_out  <= '0;
         remainder_out <= '0;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
         div_zero_out  <= 1'b0;
         overflow_out  <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               counter_r <= '0;
               if (start_in) begin
                  dvd_r    <= dividend_in;
                  dvs_r    <= divisor_in;
                  busy_out <= 1'b1;
               end
            end
            PREP: begin
               dvd_neg   <= dvd_r[OUTPUT_WIDTH-1];
               dvs_neg   <= dvs_r[INPUT_WIDTH-1];
               dvd_r     <= dvd_r[OUTPUT_WIDTH-1] ? -dvd_r : dvd_r;
               dvs_r     <= dvs_r[INPUT_WIDTH-1] ? -dvs_r : dvs_r;
               dz_r      <= (dvs_r == '0);
               prem_r    <= '0;
               counter_r <= '0;
            end
            RUN: begin
               prem_r    <= trial_ok ? trial[INPUT_WIDTH:0] : prem_shift;
               dvd_r     <= {dvd_r[OUTPUT_WIDTH-2:0], trial_ok};
               counter_r <= (counter_r == LAST_STEP) ? '0 : counter_r + 1'b1;
            end
            FINISH: begin
               busy_out <= 1'b0;
               done_out <= 1'b1;
               if (dz_r || q_ovf) begin
                  quotient_out  <= '0;
                  remainder_out <= '0;
               end else begin
                  quotient_out  <= q_val;
                  remainder_out <= r_val;
               end
               div_zero_out <= dz_r;
               overflow_out <= !dz_r && q_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed boundary cases plus randomized operands
// compared against an integer-arithmetic reference model.
module tb_seq_divider;
   localparam int IW = 6;
   localparam int OW = 12;
   localparam int CS = 4;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          start_in = 1'b0;
   logic [OW-1:0] dividend_in = '0;
   logic [IW-1:0] divisor_in = '0;
   logic [IW-1:0] quotient_out;
   logic [IW-1:0] remainder_out;
   logic          busy_out;
   logic          done_out;
   logic          div_zero_out;
   logic          overflow_out;
   logic [CS-1:0] counter_out;
   logic [1:0]    state_out;

   int total = 0;
   int bad = 0;

   seq_divider #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNTER_SIZE(CS)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
      .dividend_in(dividend_in), .divisor_in(divisor_in),
      .quotient_out(quotient_out), .remainder_out(remainder_out),
      .busy_out(busy_out), .done_out(done_out),
      .div_zero_out(div_zero_out), .overflow_out(overflow_out),
      .counter_out(counter_out), .state_out(state_out)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // reference model: plain signed integer division
   function automatic void model(input int a, input int b, output logic [IW-1:0] q,
                                 output logic [IW-1:0] r, output logic dz, output logic ov);
      int qi, ri;
      q = '0; r = '0; dz = 1'b0; ov = 1'b0;
      if (b == 0) dz = 1'b1;
      else begin
         qi = a / b;
         ri = a % b;
         if (qi > (1 << (IW - 1)) - 1 || qi < -(1 << (IW - 1))) ov = 1'b1;
         else begin
            q = IW'(qi);
            r = IW'(ri);
         end
      end
   endfunction

   // driver: start one operation, count edges to done, note busy and done-width behaviour
   task automatic run_op(input int a, input int b, output int lat, output logic busy_ok,
                         output logic done_one);
      dividend_in = OW'(a);
      divisor_in  = IW'(b);
      start_in    = 1'b1;
      step();
      start_in = 1'b0;
      lat      = 0;
      busy_ok  = 1'b1;
      while (done_out !== 1'b1 && lat < 40) begin
         if (busy_out !== 1'b1) busy_ok = 1'b0;
         step();
         lat++;
      end
      if (busy_out !== 1'b0) busy_ok = 1'b0;
      step();
      done_one = (done_out === 1'b0);
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (3) step();
      total++;
      if ({quotient_out, remainder_out, busy_out, done_out, div_zero_out, overflow_out,
           counter_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got q=%0d r=%0d busy=%b done=%b dz=%b ov=%b cnt=%0d exp all 0",
                  quotient_out, remainder_out, busy_out, done_out, div_zero_out, overflow_out,
                  counter_out);
      end
      rst_in = 1'b1;
      step();
      total++;
      if (busy_out !== 1'b0 || done_out !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy_out, done_out);
      end
   endtask

   task automatic test_arith(input int n_random);
      int da[8] = '{100, -100, 100, 192, -192, -2048, 55, 63};
      int db[8] = '{7, 7, -7, 6, 6, -1, 0, 9};
      int a, b, lat, lim, mag;
      logic busy_ok, done_one, edz, eov;
      logic [IW-1:0] eq, er;
      for (int i = 0; i < 8 + n_random; i++) begin
         if (i < 8) begin
            a = da[i];
            b = db[i];
         end else begin
            b   = int'($urandom_range(0, 63)) - 32;
            mag = (b < 0) ? -b : b;
            lim = (b == 0 || $urandom_range(0, 3) == 0) ? 2047 : 32 * mag;
            a   = int'($urandom_range(0, 2 * lim)) - lim;
            if (a > 2047) a = 2047;
         end
         model(a, b, eq, er, edz, eov);
         run_op(a, b, lat, busy_ok, done_one);
         total++;
         if (lat !== ((b == 0) ? 2 : OW + 2)) begin
            bad++;
            $display("FAIL latency a=%0d b=%0d got=%0d exp=%0d", a, b, lat, (b == 0) ? 2 : OW + 2);
         end
         total++;
         if (busy_ok !== 1'b1) begin
            bad++;
            $display("FAIL busy_window a=%0d b=%0d got=%b exp=1", a, b, busy_ok);
         end
         total++;
         if (done_one !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse_width a=%0d b=%0d got=%b exp=1", a, b, done_one);
         end
         total++;
         if (quotient_out !== eq || remainder_out !== er) begin
            bad++;
            $display("FAIL result a=%0d b=%0d got q=%0d r=%0d exp q=%0d r=%0d", a, b,
                     $signed(quotient_out), $signed(remainder_out), $signed(eq), $signed(er));
         end
         total++;
         if (div_zero_out !== edz || overflow_out !== eov) begin
            bad++;
            $display("FAIL flags a=%0d b=%0d got dz=%b ov=%b exp dz=%b ov=%b", a, b,
                     div_zero_out, overflow_out, edz, eov);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int lat, w;
      logic extra;
      dividend_in = OW'(100);
      divisor_in  = IW'(7);
      start_in    = 1'b1;
      step();
      start_in = 1'b0;
      lat = 0;
      w   = 0;
      while (counter_out !== CS'(5) && w < 30) begin
         step();
         lat++;
         w++;
      end
      total++;
      if (w >= 30) begin
         bad++;
         $display("FAIL reach_counter5 got=%0d exp=5", counter_out);
      end
      dividend_in = OW'(55);
      divisor_in  = IW'(0);
      start_in    = 1'b1;
      step();
      lat++;
      start_in = 1'b0;
      while (done_out !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      total++;
      if (lat !== OW + 2) begin
         bad++;
         $display("FAIL busy_ignore_latency got=%0d exp=%0d", lat, OW + 2);
      end
      total++;
      if ($signed(quotient_out) !== 6'sd14 || $signed(remainder_out) !== 6'sd2 ||
          div_zero_out !== 1'b0) begin
         bad++;
         $display("FAIL busy_ignore_result got q=%0d r=%0d dz=%b exp q=14 r=2 dz=0",
                  $signed(quotient_out), $signed(remainder_out), div_zero_out);
      end
      extra = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done_out !== 1'b0 || busy_out !== 1'b0) extra = 1'b1;
      end
      total++;
      if (extra !== 1'b0) begin
         bad++;
         $display("FAIL busy_ignore_no_second_op got=%b exp=0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int e, nd;
      int d[3];
      dividend_in = OW'(-100);
      divisor_in  = IW'(7);
      start_in    = 1'b1;
      e  = 0;
      nd = 0;
      while (nd < 3 && e < 100) begin
         step();
         e++;
         if (done_out === 1'b1) begin
            d[nd] = e;
            nd++;
            if (nd == 3) start_in = 1'b0;
         end
      end
      start_in = 1'b0;
      total++;
      if (nd !== 3) begin
         bad++;
         $display("FAIL b2b_done_count got=%0d exp=3", nd);
      end else begin
         total++;
         if (d[1] - d[0] !== OW + 3 || d[2] - d[1] !== OW + 3) begin
            bad++;
            $display("FAIL b2b_period got=%0d,%0d exp=%0d", d[1] - d[0], d[2] - d[1], OW + 3);
         end
      end
      total++;
      if ($signed(quotient_out) !== -6'sd14 || $signed(remainder_out) !== -6'sd2) begin
         bad++;
         $display("FAIL b2b_result got q=%0d r=%0d exp q=-14 r=-2",
                  $signed(quotient_out), $signed(remainder_out));
      end
      repeat (3) step();
      total++;
      if (busy_out !== 1'b0) begin
         bad++;
         $display("FAIL b2b_stops got busy=%b exp=0", busy_out);
      end
   endtask

   task automatic test_reset_mid_run();
      int w, lat;
      logic extra, busy_ok, done_one;
      dividend_in = OW'(100);
      divisor_in  = IW'(7);
      start_in    = 1'b1;
      step();
      start_in = 1'b0;
      w = 0;
      while (counter_out !== CS'(7) && w < 30) begin
         step();
         w++;
      end
      total++;
      if (w >= 30) begin
         bad++;
         $display("FAIL reach_counter7 got=%0d exp=7", counter_out);
      end
      #2;
      rst_in = 1'b0;
      #1;
      total++;
      if ({quotient_out, remainder_out, busy_out, done_out, div_zero_out, overflow_out,
           counter_out} !== '0) begin
         bad++;
         $display("FAIL async_reset got q=%0d r=%0d busy=%b cnt=%0d exp all 0",
                  quotient_out, remainder_out, busy_out, counter_out);
      end
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      extra = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done_out !== 1'b0 || busy_out !== 1'b0) extra = 1'b1;
      end
      total++;
      if (extra !== 1'b0) begin
         bad++;
         $display("FAIL no_done_after_abort got=%b exp=0", extra);
      end
      run_op(63, 9, lat, busy_ok, done_one);
      total++;
      if ($signed(quotient_out) !== 6'sd7 || remainder_out !== 6'd0 || lat !== OW + 2) begin
         bad++;
         $display("FAIL after_reset_op got q=%0d r=%0d lat=%0d exp q=7 r=0 lat=%0d",
                  $signed(quotient_out), $signed(remainder_out), lat, OW + 2);
      end
   endtask

   initial begin
      test_reset();
      test_arith(40);
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed restoring divider, the inverse operation of the team's Booth multiplier.
- Takes an OUTPUT_WIDTH-bit two's-complement dividend (a multiplier-width product) and an INPUT_WIDTH-bit divisor. Returns an INPUT_WIDTH-bit quotient and an INPUT_WIDTH-bit remainder.
- Quotient truncates toward zero; the remainder takes the dividend's sign.
- Start/busy/done handshake with an internal FSM. Sits beside the multiplier top; its outputs can be checked by feeding them back through the multiplier.

Parameters:
INPUT_WIDTH, 6, divisor, quotient and remainder width
OUTPUT_WIDTH, 12, dividend width; must equal 2*INPUT_WIDTH
COUNTER_SIZE, 4, iteration counter width; requires 2^COUNTER_SIZE > OUTPUT_WIDTH

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
start_in  input  1  request; sampled only in IDLE
dividend_in  input  OUTPUT_WIDTH  signed dividend; sampled with start_in
divisor_in  input  INPUT_WIDTH  signed divisor; sampled with start_in
quotient_out  output  INPUT_WIDTH  signed quotient
remainder_out  output  INPUT_WIDTH  signed remainder
busy_out  output  1  operation in progress
done_out  output  1  one-cycle completion pulse
div_zero_out  output  1  last operation had divisor == 0
overflow_out  output  1  last quotient not representable in INPUT_WIDTH bits
counter_out  output  COUNTER_SIZE  current iteration count (debug)

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE immediately.
  - All outputs and internal registers become 0, regardless of clock.
  - Reset mid-operation aborts the operation; no done_out pulse follows.
- FSM states: IDLE, PREP, RUN, FINISH.
  - IDLE: on the edge where start_in=1, latch dividend_in and divisor_in, set busy_out=1, go to PREP. start_in=0 stays in IDLE.
  - PREP (1 cycle): record both operand signs; form unsigned magnitudes (OUTPUT_WIDTH and INPUT_WIDTH bits); clear partial remainder and counter.
    - If divisor == 0, go to FINISH with the div-zero condition.
    - Otherwise go to RUN.
  - RUN (exactly OUTPUT_WIDTH cycles), one restoring step per edge:
    - Shift {partial remainder, dividend magnitude} left by 1.
    - Trial-subtract the divisor magnitude from the partial remainder.
    - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
    - Partial remainder is INPUT_WIDTH+1 bits unsigned, so no arithmetic overflow occurs.
    - counter_out increments 0..OUTPUT_WIDTH-1. After the edge with counter == OUTPUT_WIDTH-1, go to FINISH.
  - FINISH (1 cycle), then IDLE:
    - Apply signs: quotient negated if the operand signs differ; remainder negated if the dividend is negative.
    - Register results, set done_out=1, set busy_out=0.
- Overflow: the unsigned magnitude quotient is OUTPUT_WIDTH bits.
  - Signs differ: overflow if magnitude > 2^(INPUT_WIDTH-1).
  - Signs equal: overflow if magnitude > 2^(INPUT_WIDTH-1)-1.
  - On overflow: quotient_out=0, remainder_out=0, overflow_out=1.
- Div-by-zero: quotient_out=0, remainder_out=0, div_zero_out=1, overflow_out=0.
- Flags: div_zero_out and overflow_out are updated only in FINISH and held until the next FINISH.
- Results hold between operations: quotient_out and remainder_out stay stable from done until the next FINISH.
- Timing, with start sampled on edge k:
  - Normal operation: done_out high for exactly the one cycle after edge k+OUTPUT_WIDTH+2 (edge k+14 at defaults).
  - Divide-by-zero: done_out follows edge k+2.
  - busy_out is high from edge k until the edge that raises done_out.
- start_in while busy_out=1 is ignored (not queued). start_in held high through FINISH starts a new operation on the first IDLE edge, i.e. the edge after done_out rises.
- counter_out returns to 0 in IDLE.

Test Plan:
- Reset low, then release; 100 / 7 -> done 14 edges after start; quotient_out=14, remainder_out=2, flags 0.
- -100 / 7 -> quotient_out=-14 (6'b110010), remainder_out=-2. Also 100 / -7 -> quotient_out=-14, remainder_out=2.
- Overflow boundary:
  - 192 / 6 -> overflow_out=1, outputs 0.
  - -192 / 6 -> quotient_out=-32, overflow_out=0.
  - -2048 / -1 -> overflow_out=1.
- 55 / 0 -> done 2 edges after start; div_zero_out=1, quotient_out=0, remainder_out=0.
- start_in pulsed again while busy (counter_out=5) -> ignored; first result intact. Then start_in held high continuously -> back-to-back operations with done every 15 cycles.
- rst_in driven low mid-RUN (counter_out=7) between clock edges:
  - Outputs zero immediately; no done_out pulse follows.
  - A subsequent 63 / 9 gives quotient_out=7, remainder_out=0.
